// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit
//  Purpose  : Taken-branch detector; redirects the PC mux for one cycle and
//             stalls/flushes the front end for FLUSH_CYCLES cycles.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_unit #(
    parameter int                  OPCODE_W      = 4,
    parameter logic [OPCODE_W-1:0] BRANCH_OPCODE = 4'b0011,
    parameter int                  FLUSH_CYCLES  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                zeroFlag,
    input  logic [OPCODE_W-1:0] OpCode,
    output logic                stopSignal,
    output logic                selectPCMux
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REDIRECT = 2'b01,
        STALL    = 2'b10
    } state_t;

    // Counter preload; REDIRECT itself accounts for one of the stall cycles.
    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       taken;

    assign taken = (OpCode == BRANCH_OPCODE) && zeroFlag;

    // Outputs are registered alongside the state so they track the state
    // being entered, keeping inputs off any combinational output path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            stopSignal  <= 1'b0;
            selectPCMux <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (taken) begin
                        state_q     <= REDIRECT;
                        cnt_q       <= CNT_LOAD;
                        stopSignal  <= 1'b1;
                        selectPCMux <= 1'b1;
                    end else begin
                        stopSignal  <= 1'b0;
                        selectPCMux <= 1'b0;
                    end
                end
                REDIRECT: begin
                    selectPCMux <= 1'b0;
                    if (cnt_q == 4'd0) begin
                        state_q    <= IDLE;
                        stopSignal <= 1'b0;
                    end else begin
                        state_q    <= STALL;
                        stopSignal <= 1'b1;
                    end
                end
                STALL: begin
                    selectPCMux <= 1'b0;
                    // <= rather than == so a corrupted zero count cannot wrap.
                    if (cnt_q <= 4'd1) begin
                        state_q    <= IDLE;
                        cnt_q      <= 4'd0;
                        stopSignal <= 1'b0;
                    end else begin
                        cnt_q      <= cnt_q - 4'd1;
                        stopSignal <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= 4'd0;
                    stopSignal  <= 1'b0;
                    selectPCMux <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_unit
//  Purpose  : Directed-vector scoreboard bench for hazard_unit (FLUSH_CYCLES=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       zeroFlag = 1'b0;
    logic [3:0] OpCode = 4'b0000;
    logic       stopSignal;
    logic       selectPCMux;

    int n_checks = 0;
    int n_errors = 0;
    int vec_id   = 0;

    typedef struct {
        int   id;
        logic stop;
        logic sel;
    } exp_t;

    exp_t sb_q[$];

    hazard_unit #(
        .OPCODE_W     (4),
        .BRANCH_OPCODE(4'b0011),
        .FLUSH_CYCLES (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .zeroFlag   (zeroFlag),
        .OpCode     (OpCode),
        .stopSignal (stopSignal),
        .selectPCMux(selectPCMux)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are valid every cycle, sampled 1 unit after the edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (stopSignal !== e.stop || selectPCMux !== e.sel) begin
                n_errors++;
                $display("FAIL vec%0d: got stop=%b sel=%b, expected stop=%b sel=%b",
                         e.id, stopSignal, selectPCMux, e.stop, e.sel);
            end
        end
    end

    // Drive one cycle of inputs at the falling edge and queue the outputs
    // expected after the following rising edge.
    task automatic step(input logic rst, input logic [3:0] op, input logic z,
                        input logic exp_stop, input logic exp_sel);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        OpCode   = op;
        zeroFlag = z;
        e.id     = vec_id;
        e.stop   = exp_stop;
        e.sel    = exp_sel;
        vec_id++;
        sb_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic exp_stop, input logic exp_sel);
        n_checks++;
        if (stopSignal !== exp_stop || selectPCMux !== exp_sel) begin
            n_errors++;
            $display("FAIL %s: got stop=%b sel=%b, expected stop=%b sel=%b",
                     name, stopSignal, selectPCMux, exp_stop, exp_sel);
        end
    endtask

    initial begin
        // Reset held low with a taken branch presented.
        step(0, 4'b0011, 1, 0, 0);
        step(0, 4'b0011, 1, 0, 0);

        // No hazard: non-branch opcode, zeroFlag toggling.
        step(1, 4'b0000, 0, 0, 0);
        step(1, 4'b0000, 1, 0, 0);
        step(1, 4'b0000, 0, 0, 0);
        step(1, 4'b0000, 1, 0, 0);
        // Branch opcode, not taken.
        for (int i = 0; i < 4; i++) step(1, 4'b0011, 0, 0, 0);

        // Single taken branch.
        step(1, 4'b0011, 1, 1, 1);
        step(1, 4'b0000, 0, 1, 0);
        step(1, 4'b0000, 0, 1, 0);
        step(1, 4'b0000, 1, 0, 0);
        step(1, 4'b0000, 0, 0, 0);

        // Held hazard: 3 high, 1 low, repeat.
        step(1, 4'b0011, 1, 1, 1);
        step(1, 4'b0011, 1, 1, 0);
        step(1, 4'b0011, 1, 1, 0);
        step(1, 4'b0011, 1, 0, 0);
        step(1, 4'b0011, 1, 1, 1);
        step(1, 4'b0011, 1, 1, 0);
        step(1, 4'b0011, 1, 1, 0);
        step(1, 4'b0011, 1, 0, 0);
        step(1, 4'b0000, 0, 0, 0);

        // Condition drops mid-burst, burst completes, then re-raise.
        step(1, 4'b0011, 1, 1, 1);
        step(1, 4'b0011, 0, 1, 0);
        step(1, 4'b0011, 0, 1, 0);
        step(1, 4'b0011, 0, 0, 0);
        step(1, 4'b0011, 0, 0, 0);
        step(1, 4'b0011, 1, 1, 1);
        step(1, 4'b0000, 0, 1, 0);
        step(1, 4'b0000, 0, 1, 0);
        step(1, 4'b0000, 0, 0, 0);

        // Reset mid-flush, asserted between edges.
        step(1, 4'b0011, 1, 1, 1);
        step(1, 4'b0000, 0, 1, 0);
        @(posedge clk);
        #3;
        check_now("stall_before_reset", 1, 0);
        reset = 1'b0;
        #1;
        check_now("async_reset_mid_flush", 0, 0);
        step(0, 4'b0000, 0, 0, 0);
        step(1, 4'b0000, 0, 0, 0);
        step(1, 4'b0000, 0, 0, 0);
        step(1, 4'b0000, 0, 0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
